// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decoder
// Purpose  : Single-entry decode stage that maps LA32R integer ALU
//            instructions onto a 12-bit one-hot ALU control word, register
//            addresses, operand-2 select and an extended immediate.
//            Uses a valid/ready handshake with full throughput and a
//            synchronous flush that kills the held entry.
// Ports    : clk, resetn (async, active low), flush
//            in_valid/in_ready/in_inst/in_pc      - upstream handshake
//            out_valid/out_ready/out_pc           - downstream handshake
//            alu_control, rj_addr, rk_addr, rd_addr, src2_is_imm, imm,
//            rf_we, ine                           - registered decode result
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decoder #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [11:0]     alu_control,
    output logic [4:0]      rj_addr,
    output logic [4:0]      rk_addr,
    output logic [4:0]      rd_addr,
    output logic            src2_is_imm,
    output logic [31:0]     imm,
    output logic            rf_we,
    output logic            ine
);

    // One-hot bit positions inside alu_control
    localparam int c_ALU_ADD  = 11;
    localparam int c_ALU_SUB  = 10;
    localparam int c_ALU_SLT  = 9;
    localparam int c_ALU_SLTU = 8;
    localparam int c_ALU_AND  = 7;
    localparam int c_ALU_NOR  = 6;
    localparam int c_ALU_OR   = 5;
    localparam int c_ALU_XOR  = 4;
    localparam int c_ALU_SLL  = 3;
    localparam int c_ALU_SRL  = 2;
    localparam int c_ALU_SRA  = 1;
    localparam int c_ALU_LUI  = 0;

    // Opcode fields of the three encoding families
    logic [16:0] w_op17;
    logic [9:0]  w_op10;
    logic [6:0]  w_op7;

    // Combinational decode of the incoming word
    logic [11:0] w_alu_control;
    logic [4:0]  w_rj_addr;
    logic [4:0]  w_rk_addr;
    logic [4:0]  w_rd_addr;
    logic        w_src2_is_imm;
    logic [31:0] w_imm;
    logic        w_legal;
    logic        w_accept;

    // Registered entry
    logic            r_out_valid;
    logic [PC_W-1:0] r_out_pc;
    logic [11:0]     r_alu_control;
    logic [4:0]      r_rj_addr;
    logic [4:0]      r_rk_addr;
    logic [4:0]      r_rd_addr;
    logic            r_src2_is_imm;
    logic [31:0]     r_imm;
    logic            r_rf_we;
    logic            r_ine;

    assign w_op17 = in_inst[31:15];
    assign w_op10 = in_inst[31:22];
    assign w_op7  = in_inst[31:25];

    // in_ready deliberately ignores flush so the upstream handshake stays
    // purely a function of the held entry; a flushed accept is dropped below.
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    always_comb begin
        w_alu_control = 12'b0;
        w_rj_addr     = in_inst[9:5];
        w_rk_addr     = in_inst[14:10];
        w_rd_addr     = in_inst[4:0];
        w_src2_is_imm = 1'b0;
        w_imm         = 32'b0;
        w_legal       = 1'b1;

        case (w_op17)
            // 3R register-register forms
            17'h00020: w_alu_control[c_ALU_ADD]  = 1'b1;
            17'h00022: w_alu_control[c_ALU_SUB]  = 1'b1;
            17'h00024: w_alu_control[c_ALU_SLT]  = 1'b1;
            17'h00025: w_alu_control[c_ALU_SLTU] = 1'b1;
            17'h00028: w_alu_control[c_ALU_NOR]  = 1'b1;
            17'h00029: w_alu_control[c_ALU_AND]  = 1'b1;
            17'h0002A: w_alu_control[c_ALU_OR]   = 1'b1;
            17'h0002B: w_alu_control[c_ALU_XOR]  = 1'b1;
            // Shift-immediate forms: the shift amount sits where rk would be
            17'h00081, 17'h00089, 17'h00091: begin
                w_src2_is_imm = 1'b1;
                w_imm         = {27'b0, in_inst[14:10]};
                w_rk_addr     = 5'd0;
                if (w_op17 == 17'h00081)
                    w_alu_control[c_ALU_SLL] = 1'b1;
                else if (w_op17 == 17'h00089)
                    w_alu_control[c_ALU_SRL] = 1'b1;
                else
                    w_alu_control[c_ALU_SRA] = 1'b1;
            end
            default: begin
                case (w_op10)
                    // Arithmetic/compare immediates are sign-extended
                    10'h008, 10'h009, 10'h00A: begin
                        w_src2_is_imm = 1'b1;
                        w_rk_addr     = 5'd0;
                        w_imm         = {{20{in_inst[21]}}, in_inst[21:10]};
                        if (w_op10 == 10'h008)
                            w_alu_control[c_ALU_SLT] = 1'b1;
                        else if (w_op10 == 10'h009)
                            w_alu_control[c_ALU_SLTU] = 1'b1;
                        else
                            w_alu_control[c_ALU_ADD] = 1'b1;
                    end
                    // Logical immediates are zero-extended
                    10'h00D, 10'h00E, 10'h00F: begin
                        w_src2_is_imm = 1'b1;
                        w_rk_addr     = 5'd0;
                        w_imm         = {20'b0, in_inst[21:10]};
                        if (w_op10 == 10'h00D)
                            w_alu_control[c_ALU_AND] = 1'b1;
                        else if (w_op10 == 10'h00E)
                            w_alu_control[c_ALU_OR] = 1'b1;
                        else
                            w_alu_control[c_ALU_XOR] = 1'b1;
                    end
                    default: begin
                        if (w_op7 == 7'h0A) begin
                            // lu12i.w has no register sources
                            w_alu_control[c_ALU_LUI] = 1'b1;
                            w_src2_is_imm = 1'b1;
                            w_imm         = {in_inst[24:5], 12'b0};
                            w_rj_addr     = 5'd0;
                            w_rk_addr     = 5'd0;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_alu_control <= 12'b0;
            r_rj_addr     <= 5'd0;
            r_rk_addr     <= 5'd0;
            r_rd_addr     <= 5'd0;
            r_src2_is_imm <= 1'b0;
            r_imm         <= 32'b0;
            r_rf_we       <= 1'b0;
            r_ine         <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            // Also covers drain+accept in the same cycle (entry replaced)
            r_out_valid   <= 1'b1;
            r_out_pc      <= in_pc;
            r_alu_control <= w_alu_control;
            r_rj_addr     <= w_rj_addr;
            r_rk_addr     <= w_rk_addr;
            r_rd_addr     <= w_rd_addr;
            r_src2_is_imm <= w_src2_is_imm;
            r_imm         <= w_imm;
            r_rf_we       <= w_legal & (w_rd_addr != 5'd0);
            r_ine         <= ~w_legal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign alu_control = r_alu_control;
    assign rj_addr     = r_rj_addr;
    assign rk_addr     = r_rk_addr;
    assign rd_addr     = r_rd_addr;
    assign src2_is_imm = r_src2_is_imm;
    assign imm         = r_imm;
    assign rf_we       = r_rf_we;
    assign ine         = r_ine;

endmodule
`default_nettype wire
